// File: rtl/pattern_producer.sv
// Multi-channel deterministic stimulus source: walking-bit, counter and Galois LFSR
// sequences per channel, with valid/ready handshake, end-of-sequence marking and flush.
module pattern_producer #(
  parameter int                N_CH    = 2,
  parameter int                DATA_W  = 32,
  parameter int                SEQ_LEN = 8,
  parameter logic [DATA_W-1:0] SEED    = DATA_W'(32'h0001_0000),
  parameter logic [DATA_W-1:0] TAPS    = DATA_W'(32'h8020_0003)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [1:0]               mode,
  output logic [N_CH*DATA_W-1:0]   out_data,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic [N_CH-1:0]          out_last,
  output logic [N_CH-1:0]          flush
);

  localparam int IDX_W = $clog2(SEQ_LEN);

  localparam logic [1:0] MODE_WALK  = 2'd0;
  localparam logic [1:0] MODE_COUNT = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              mode_q, mode_d;
  logic [IDX_W-1:0]        idx_q  [N_CH];
  logic [IDX_W-1:0]        idx_d  [N_CH];
  logic [DATA_W-1:0]       lfsr_q [N_CH];
  logic [DATA_W-1:0]       lfsr_d [N_CH];
  logic [N_CH*DATA_W-1:0]  data_q, data_d;
  logic [N_CH-1:0]         valid_q, valid_d;
  logic [N_CH-1:0]         last_q, last_d;
  logic [N_CH-1:0]         flush_q, flush_d;

  // An all-zero LFSR would lock up, so a zero load value is replaced by 1.
  function automatic logic [DATA_W-1:0] lfsr_load(input int c);
    logic [DATA_W-1:0] v;
    v = SEED ^ DATA_W'(c);
    if (v == '0) v = DATA_W'(1);
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] v);
    return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                input int                c,
                                                input logic [IDX_W-1:0]  i,
                                                input logic [DATA_W-1:0] l);
    logic [DATA_W-1:0] w;
    case (m)
      MODE_WALK:  w = ((c % 2) == 0) ? (SEED << i) : (SEED >> i);
      MODE_COUNT: w = SEED + DATA_W'(i) + DATA_W'(c);
      MODE_LFSR:  w = l;
      default:    w = '0;
    endcase
    return w;
  endfunction

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
          mode_d  = mode;
        end
      end
      ST_RUN: begin
        if (!enable || (mode != mode_q)) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (enable) begin
          state_d = ST_RUN;
          mode_d  = mode;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from next-state values so they can be registered
  // without adding a cycle of latency after the handshake or state change.
  always_comb begin
    data_d  = '0;
    valid_d = '0;
    last_d  = '0;
    flush_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      idx_d[c]  = idx_q[c];
      lfsr_d[c] = lfsr_q[c];
      if (state_d != ST_RUN) begin
        idx_d[c]  = '0;
        lfsr_d[c] = lfsr_load(c);
      end else if (valid_q[c] && out_ready[c]) begin
        idx_d[c]  = idx_q[c] + IDX_W'(1);
        lfsr_d[c] = lfsr_step(lfsr_q[c]);
      end
      valid_d[c] = (state_d == ST_RUN) && (mode_d != MODE_RSVD);
      flush_d[c] = (state_d == ST_FLUSH);
      last_d[c]  = valid_d[c] && (idx_d[c] == IDX_W'(SEQ_LEN - 1));
      if (valid_d[c]) data_d[c*DATA_W +: DATA_W] = pattern(mode_d, c, idx_d[c], lfsr_d[c]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      data_q  <= '0;
      valid_q <= '0;
      last_q  <= '0;
      flush_q <= '0;
      for (int c = 0; c < N_CH; c++) begin
        idx_q[c]  <= '0;
        lfsr_q[c] <= lfsr_load(c);
      end
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      flush_q <= flush_d;
      for (int c = 0; c < N_CH; c++) begin
        idx_q[c]  <= idx_d[c];
        lfsr_q[c] <= lfsr_d[c];
      end
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign flush     = flush_q;

endmodule
